// File: rtl/regfile_read_arbiter_pkg.sv
// Register-file geometry shared by the read arbiter and the register file,
// plus the write-forwarding match used when capturing a granted read.
package regfile_read_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;

  // Register 0 is hard-wired, so a write to it never overrides the port value.
  function automatic logic fwd_hit(
    input logic                  we,
    input logic [REG_ADDR_W-1:0] wr_addr,
    input logic [REG_ADDR_W-1:0] rd_addr
  );
    return we && (wr_addr == rd_addr) && (rd_addr != '0);
  endfunction

endpackage

// File: rtl/regfile_read_arbiter_rr_pick.sv
// Combinational round-robin picker: the first eligible index at or after
// rr_ptr (wrapping modulo NUM_REQ) wins.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  logic [PTR_W:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!any && elig[cand[PTR_W-1:0]]) begin
        any = 1'b1;
        idx = cand[PTR_W-1:0];
      end
    end
    gnt[idx] = any;
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin sharing of one register-file read port among NUM_REQ
// four-phase requesters, with same-cycle write forwarding into the responses.
module regfile_read_arbiter
  import regfile_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                             clock,
  input  logic                             ctrl_reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [REG_ADDR_W*NUM_REQ-1:0]    req_addr,
  output logic [REG_ADDR_W-1:0]            ctrl_readReg,
  output logic                             port_en,
  input  logic [REG_DATA_W-1:0]            read_data,
  input  logic                             ctrl_writeEnable,
  input  logic [REG_ADDR_W-1:0]            ctrl_writeReg,
  input  logic [REG_DATA_W-1:0]            data_writeReg,
  output logic [NUM_REQ-1:0]               grant,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [REG_DATA_W*NUM_REQ-1:0]    rsp_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0][REG_ADDR_W-1:0] addr_arr;
  logic [NUM_REQ-1:0]                 done_q, done_d;
  logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0][REG_DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    pick_gnt;
  logic [PTR_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  gnt_vld;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [REG_DATA_W-1:0] cap_word;

  assign addr_arr = req_addr;
  assign elig     = req_valid & ~done_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .elig   (elig),
    .rr_ptr (rr_ptr_q),
    .gnt    (pick_gnt),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Grants are suppressed while reset is held so the port stays quiet.
  assign gnt_vld  = pick_any & ~ctrl_reset;
  assign sel_addr = addr_arr[pick_idx];

  always_comb begin
    grant        = gnt_vld ? pick_gnt : '0;
    port_en      = gnt_vld;
    ctrl_readReg = gnt_vld ? sel_addr : '0;
    cap_word     = fwd_hit(ctrl_writeEnable, ctrl_writeReg, sel_addr) ? data_writeReg : read_data;

    done_d     = done_q & req_valid;
    rsp_data_d = rsp_data_q;
    rr_ptr_d   = rr_ptr_q;
    if (gnt_vld) begin
      done_d[pick_idx]     = 1'b1;
      rsp_data_d[pick_idx] = cap_word;
      rr_ptr_d             = (pick_idx == PTR_W'(NUM_REQ-1)) ? '0 : pick_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      done_q     <= '0;
      rr_ptr_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      done_q     <= done_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign rsp_valid = done_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed and randomized bench for regfile_read_arbiter against a
// transaction-level model of arbitration, forwarding and the handshake.
module tb_regfile_read_arbiter;

  localparam int N = 4;

  logic            clock = 1'b0;
  logic            ctrl_reset;
  logic [N-1:0]    req_valid;
  logic [5*N-1:0]  req_addr;
  logic [4:0]      ctrl_readReg;
  logic            port_en;
  logic [31:0]     read_data;
  logic            ctrl_writeEnable;
  logic [4:0]      ctrl_writeReg;
  logic [31:0]     data_writeReg;
  logic [N-1:0]    grant;
  logic [N-1:0]    rsp_valid;
  logic [32*N-1:0] rsp_data;

  logic [31:0] regs [32];

  always #5 clock = ~clock;

  assign read_data = regs[ctrl_readReg];

  regfile_read_arbiter #(.NUM_REQ(N)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .ctrl_readReg     (ctrl_readReg),
    .port_en          (port_en),
    .read_data        (read_data),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .grant            (grant),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data)
  );

  int tests  = 0;
  int failed = 0;

  // Transaction-level model state
  logic [N-1:0] m_done;
  logic [31:0]  m_rsp [N];
  int           m_ptr;
  int           m_wait [N];
  int           g_count [N];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_done = '0;
    m_ptr  = 0;
    for (int i = 0; i < N; i++) begin
      m_rsp[i]  = 32'h0;
      m_wait[i] = 0;
    end
  endtask

  // Called just after a rising edge with inputs already driven: checks the
  // cycle's outputs, advances the model, and crosses the next edge.
  task automatic cycle();
    int           g;
    logic [N-1:0] elig;
    logic [N-1:0] eg;
    logic [4:0]   a;
    logic [31:0]  cap;
    logic         pw;
    logic [4:0]   pwa;
    logic [31:0]  pwd;
    #3;
    if (ctrl_reset) model_reset();
    elig = ctrl_reset ? '0 : (req_valid & ~m_done);
    g    = -1;
    for (int d = 0; d < N; d++) begin
      if (g < 0 && elig[(m_ptr + d) % N]) g = (m_ptr + d) % N;
    end
    eg  = '0;
    a   = 5'd0;
    cap = 32'h0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      a     = req_addr[5*g +: 5];
      cap   = (ctrl_writeEnable && ctrl_writeReg == a && a != 5'd0) ? data_writeReg : regs[a];
    end
    chk("grant", grant, eg);
    chk("port_en", port_en, g >= 0);
    chk("ctrl_readReg", ctrl_readReg, a);
    chk("rsp_valid", rsp_valid, m_done);
    for (int i = 0; i < N; i++) chk($sformatf("rsp_data[%0d]", i), rsp_data[32*i +: 32], m_rsp[i]);
    if (g >= 0) begin
      chk($sformatf("wait_bound[%0d]", g), m_wait[g] <= N - 1, 1'b1);
      g_count[g]++;
    end
    for (int i = 0; i < N; i++) begin
      if (elig[i] && i != g) m_wait[i]++;
      else m_wait[i] = 0;
    end
    m_done = (m_done & req_valid) | eg;
    if (g >= 0) begin
      m_rsp[g] = cap;
      m_ptr    = (g + 1) % N;
    end
    pw  = ctrl_writeEnable && ctrl_writeReg != 5'd0;
    pwa = ctrl_writeReg;
    pwd = data_writeReg;
    @(posedge clock);
    #1;
    if (pw) regs[pwa] = pwd;
  endtask

  initial begin
    regs[0] = 32'h0;
    for (int k = 1; k < 32; k++) regs[k] = $urandom;
    regs[7]  = 32'h0000_1234;
    regs[12] = 32'hA5A5_0C0C;
    for (int i = 0; i < N; i++) g_count[i] = 0;
    model_reset();
    ctrl_reset       = 1'b1;
    req_valid        = '1;
    req_addr         = {5'd3, 5'd2, 5'd1, 5'd7};
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'h0;

    // Reset held with every requester active: everything stays at zero.
    @(posedge clock);
    #1;
    cycle();
    cycle();

    // Release: requesters 0..3 are served in order, one per cycle.
    ctrl_reset = 1'b0;
    for (int c = 0; c < 5; c++) cycle();
    chk("rr_order_counts", {g_count[3][7:0], g_count[2][7:0], g_count[1][7:0], g_count[0][7:0]}, 32'h01010101);
    req_valid = '0;
    cycle();
    cycle();

    // Single request to reg 7 from requester 2.
    req_valid[2]     = 1'b1;
    req_addr[10 +: 5] = 5'd7;
    cycle();
    cycle();
    chk("single_rsp_data", rsp_data[64 +: 32], 32'h0000_1234);
    req_valid[2] = 1'b0;
    cycle();
    cycle();

    // Forwarding of a same-cycle write to reg 5.
    req_valid[0]     = 1'b1;
    req_addr[0 +: 5] = 5'd5;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd5;
    data_writeReg    = 32'hDEAD_BEEF;
    cycle();
    chk("fwd_reg5", rsp_data[0 +: 32], 32'hDEAD_BEEF);
    ctrl_writeEnable = 1'b0;
    req_valid[0]     = 1'b0;
    cycle();
    cycle();

    // A write to reg 0 is never forwarded.
    req_valid[1]     = 1'b1;
    req_addr[5 +: 5] = 5'd0;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'hFFFF_FFFF;
    cycle();
    chk("fwd_reg0", rsp_data[32 +: 32], 32'h0);
    ctrl_writeEnable = 1'b0;
    req_valid[1]     = 1'b0;
    cycle();
    cycle();

    // Held request: one grant only, acknowledge stays up.
    g_count[1]       = 0;
    req_valid[1]     = 1'b1;
    req_addr[5 +: 5] = 5'd9;
    for (int c = 0; c < 11; c++) cycle();
    chk("held_grant_count", g_count[1], 1);
    chk("held_rsp_valid", rsp_valid[1], 1'b1);
    req_valid[1] = 1'b0;
    cycle();
    cycle();

    // Reset lands in the cycle requester 3 is granted.
    req_valid[3]      = 1'b1;
    req_addr[15 +: 5] = 5'd12;
    #2;
    chk("pre_reset_grant", grant, 4'b1000);
    ctrl_reset = 1'b1;
    cycle();
    chk("reset_rsp_valid", rsp_valid, 4'b0000);
    ctrl_reset = 1'b0;
    cycle();
    cycle();
    chk("regrant_data", rsp_data[96 +: 32], 32'hA5A5_0C0C);
    req_valid[3] = 1'b0;
    cycle();
    cycle();

    // Randomized four-phase traffic with random writes.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if (!m_done[i] && $urandom_range(0, 1) == 1) begin
            req_valid[i]        = 1'b1;
            req_addr[5*i +: 5]  = 5'($urandom_range(0, 31));
          end
        end else if (m_done[i] && $urandom_range(0, 9) < 7) begin
          req_valid[i] = 1'b0;
        end
      end
      ctrl_writeEnable = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) ctrl_writeReg = req_addr[5*$urandom_range(0, N-1) +: 5];
      else ctrl_writeReg = 5'($urandom_range(0, 31));
      data_writeReg = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
